gesture_frame_sequencer: RTL

- Frame-level controller for the gesture pipeline.
- On each `start`, reads the stored binary frame out of the frame buffer twice: pass 0 feeds the palm-extraction unit, pass 1 feeds the finger-identification unit.
- Generates raster row/col coordinates and clear pulses, gates pass 1 on palm presence, and returns a per-frame gesture result over a valid/ready handshake.

---
 rtl/gesture_pkg.sv | 39 +++
 rtl/gesture_frame_sequencer_raster_addr_gen.sv | 61 ++++++
 rtl/gesture_frame_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/gesture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gesture_pkg
//  Description : Shared types and constants for the gesture frame sequencer:
//                FSM state enum, finger bit indices, default image size and a
//                5-bit popcount helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package gesture_pkg;

    localparam int DEF_IMG_W = 120;
    localparam int DEF_IMG_H = 160;

    // Bit positions within finger_status / result_fingers
    localparam int THUMB  = 0;
    localparam int INDEX  = 1;
    localparam int MIDDLE = 2;
    localparam int RING   = 3;
    localparam int PINKY  = 4;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_CLR_PALM     = 4'd1,
        S_SCAN_PALM    = 4'd2,
        S_DRAIN_PALM   = 4'd3,
        S_CHECK        = 4'd4,
        S_CLR_FINGER   = 4'd5,
        S_SCAN_FINGER  = 4'd6,
        S_DRAIN_FINGER = 4'd7,
        S_RESULT       = 4'd8
    } state_t;

    function automatic logic [2:0] popcount5(input logic [4:0] v);
        return {2'b00, v[THUMB]} + {2'b00, v[INDEX]} + {2'b00, v[MIDDLE]}
             + {2'b00, v[RING]}  + {2'b00, v[PINKY]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gesture_frame_sequencer_raster_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : raster_addr_gen
//  Description : Row-major raster walker. Produces the frame-buffer address
//                and the matching row/col coordinates, plus a flag marking
//                the final pixel of the frame.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                clr_i       - return all counters to 0
//                en_i        - advance one pixel
//                addr_o      - linear address (ADDR_W bits)
//                row_o/col_o - coordinates of addr_o
//                last_o      - addr_o is the last pixel of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_addr_gen #(
    parameter int IMG_W  = 120,
    parameter int IMG_H  = 160,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        row_o,
    output logic [7:0]        col_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [7:0]        LAST_COL  = 8'(IMG_W - 1);

    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        row_q;
    logic [7:0]        col_q;

    assign last_o = (addr_q == LAST_ADDR);
    assign addr_o = addr_q;
    assign row_o  = row_q;
    assign col_o  = col_q;

    // Stepping past the last pixel returns to 0, so the counter never wraps
    // through the address space within a pass.
    always_ff @(posedge clk) begin
        if (rst || clr_i || (en_i && last_o)) begin
            addr_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (en_i) begin
            addr_q <= addr_q + 1'b1;
            if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gesture_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gesture_frame_sequencer
//  Description : Frame-level controller. Each start reads the stored binary
//                frame twice (pass 0 -> palm unit, pass 1 -> finger unit),
//                gates pass 1 on palm presence and returns one gesture result
//                per frame over a valid/ready handshake.
//  Config      : define SEQ_STABLE_EN to present a finger result only when it
//                repeats the previous frame's finger status.
//  Ports       : start_i / busy_o              - frame control
//                fb_rd_en_o / fb_rd_addr_o /
//                fb_rd_data_i                  - frame-buffer read port
//                pix_*_o / pass_sel_o          - pixel beats to units
//                palm_clr_o / finger_clr_o     - unit clear pulses
//                palm_found_i / finger_status_i- unit results
//                result_*                      - gesture result handshake
//  Note        : IMG_W*IMG_H must fit in ADDR_W bits; DRAIN >= 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module gesture_frame_sequencer
    import gesture_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 15,
    parameter int DRAIN  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              fb_rd_en_o,
    output logic [ADDR_W-1:0] fb_rd_addr_o,
    input  logic              fb_rd_data_i,
    output logic              pix_valid_o,
    output logic              pix_data_o,
    output logic [7:0]        pix_row_o,
    output logic [7:0]        pix_col_o,
    output logic              pass_sel_o,
    output logic              palm_clr_o,
    output logic              finger_clr_o,
    input  logic              palm_found_i,
    input  logic [4:0]        finger_status_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [4:0]        result_fingers_o,
    output logic [2:0]        result_count_o,
    output logic              result_nopalm_o
);

    localparam int                DCW        = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(DRAIN - 1);

    state_t            state_q, state_d;
    logic [DCW-1:0]    drain_q, drain_d;
    logic [4:0]        fingers_q, fingers_d;
    logic [2:0]        count_q, count_d;
    logic              nopalm_q, nopalm_d;
    logic              pix_valid_q;
    logic [7:0]        pix_row_q, pix_col_q;
`ifdef SEQ_STABLE_EN
    logic [4:0]        prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
`endif

    logic              gen_clr, gen_en, gen_last;
    logic [ADDR_W-1:0] gen_addr;
    logic [7:0]        gen_row, gen_col;

    raster_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_raster (
        .clk   (clk),
        .rst   (rst),
        .clr_i (gen_clr),
        .en_i  (gen_en),
        .addr_o(gen_addr),
        .row_o (gen_row),
        .col_o (gen_col),
        .last_o(gen_last)
    );

    assign busy_o         = (state_q != S_IDLE);
    assign fb_rd_en_o     = (state_q == S_SCAN_PALM) || (state_q == S_SCAN_FINGER);
    assign fb_rd_addr_o   = gen_addr;
    assign palm_clr_o     = (state_q == S_CLR_PALM);
    assign finger_clr_o   = (state_q == S_CLR_FINGER);
    assign pass_sel_o     = (state_q == S_CLR_FINGER) || (state_q == S_SCAN_FINGER)
                         || (state_q == S_DRAIN_FINGER);
    assign result_valid_o = (state_q == S_RESULT);
    assign gen_clr        = palm_clr_o || finger_clr_o;
    assign gen_en         = fb_rd_en_o;

    assign pix_valid_o      = pix_valid_q;
    assign pix_row_o        = pix_row_q;
    assign pix_col_o        = pix_col_q;
    // The frame buffer's own read register supplies the pipeline stage, so
    // its data lines up with the registered beat; gating keeps it 0 off-beat.
    assign pix_data_o       = fb_rd_data_i & pix_valid_q;
    assign result_fingers_o = fingers_q;
    assign result_count_o   = count_q;
    assign result_nopalm_o  = nopalm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            drain_q      <= '0;
            fingers_q    <= '0;
            count_q      <= '0;
            nopalm_q     <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_row_q    <= '0;
            pix_col_q    <= '0;
`ifdef SEQ_STABLE_EN
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            fingers_q    <= fingers_d;
            count_q      <= count_d;
            nopalm_q     <= nopalm_d;
            pix_valid_q  <= fb_rd_en_o;
            pix_row_q    <= gen_row;
            pix_col_q    <= gen_col;
`ifdef SEQ_STABLE_EN
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        fingers_d    = fingers_q;
        count_d      = count_q;
        nopalm_d     = nopalm_q;
`ifdef SEQ_STABLE_EN
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
`endif
        case (state_q)
            S_IDLE:       if (start_i) state_d = S_CLR_PALM;
            S_CLR_PALM:   state_d = S_SCAN_PALM;
            S_SCAN_PALM: begin
                if (gen_last) begin
                    state_d = S_DRAIN_PALM;
                    drain_d = '0;
                end
            end
            S_DRAIN_PALM: begin
                if (drain_q == DRAIN_LAST) state_d = S_CHECK;
                else                       drain_d = drain_q + 1'b1;
            end
            S_CHECK: begin
                if (palm_found_i) begin
                    state_d = S_CLR_FINGER;
                end else begin
                    fingers_d = '0;
                    count_d   = '0;
                    nopalm_d  = 1'b1;
`ifdef SEQ_STABLE_EN
                    prev_valid_d = 1'b0;
`endif
                    state_d   = S_RESULT;
                end
            end
            S_CLR_FINGER: state_d = S_SCAN_FINGER;
            S_SCAN_FINGER: begin
                if (gen_last) begin
                    state_d = S_DRAIN_FINGER;
                    drain_d = '0;
                end
            end
            S_DRAIN_FINGER: begin
                if (drain_q == DRAIN_LAST) begin
`ifdef SEQ_STABLE_EN
                    // Only a status that repeats the previous frame is shown
                    if (prev_valid_q && (finger_status_i == prev_q)) begin
                        fingers_d = finger_status_i;
                        count_d   = popcount5(finger_status_i);
                        nopalm_d  = 1'b0;
                        state_d   = S_RESULT;
                    end else begin
                        prev_d       = finger_status_i;
                        prev_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end
`else
                    fingers_d = finger_status_i;
                    count_d   = popcount5(finger_status_i);
                    nopalm_d  = 1'b0;
                    state_d   = S_RESULT;
`endif
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_RESULT:     if (result_ready_i) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
